axi_w_router: RTL

//  Parametrised write-data router for the AXI node slave side. Takes per-burst routing entries
//  (one-hot destination, AWLEN, decode-error flag) from the AW decoder and steers W beats to
//  one of N_INIT_PORT master ports in AW order. Beat counting against AWLEN regenerates WLAST.
//  A built-in error sink absorbs bursts with a decode error. WLAST mismatches are flagged.

---
 rtl/axi_node_pkg.sv | 18 +
 rtl/generic_fifo.sv | 61 ++++++
 rtl/axi_w_router.sv | 113 +++++++++++
 3 files changed

// File: rtl/axi_node_pkg.sv
// Shared types and constants for the AXI node write-data path.
package axi_node_pkg;

  localparam int unsigned AxiNInitPort = 4;
  localparam int unsigned AxiLenWidth  = 8;

  // Routing entry as produced by the AW decoder of a default-sized node.
  typedef struct packed {
    logic                    error;
    logic [AxiNInitPort-1:0] dest;
    logic [AxiLenWidth-1:0]  len;
  } w_route_entry_t;

  localparam logic [1:0] ModeIdle  = 2'd0;
  localparam logic [1:0] ModeRoute = 2'd1;
  localparam logic [1:0] ModeSink  = 2'd2;

endpackage

// File: rtl/generic_fifo.sv
// Synchronous FIFO without fall-through; a full FIFO accepts a push in a cycle that also pops.
module generic_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  test_en_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  gnt_o,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  full, do_push, do_pop, cg_en;

  function automatic logic [AddrW-1:0] ptr_inc(input logic [AddrW-1:0] p);
    return (p == AddrW'(DEPTH - 1)) ? '0 : p + AddrW'(1);
  endfunction

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign gnt_o   = ~full | pop_i;
  assign do_push = push_i & gnt_o;
  assign do_pop  = pop_i & ~empty_o;
  // Clock-gate enable for the control state; test mode keeps the gate open.
  assign cg_en   = do_push | do_pop | test_en_i;

  always_comb begin
    wptr_d = do_push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = do_pop ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (cg_en) begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign data_o = mem_q[rptr_q];

endmodule

// File: rtl/axi_w_router.sv
// Steers W beats to the master port named by the head routing entry, regenerating WLAST by count.
module axi_w_router
  import axi_node_pkg::*;
#(
  parameter int unsigned N_INIT_PORT = 4,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned LEN_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   test_en_i,
  input  logic                   push_DEST_i,
  output logic                   grant_FIFO_DEST_o,
  input  logic [N_INIT_PORT-1:0] DEST_i,
  input  logic [LEN_WIDTH-1:0]   len_i,
  input  logic                   error_i,
  input  logic                   wvalid_i,
  input  logic                   wlast_i,
  output logic                   wready_o,
  output logic [N_INIT_PORT-1:0] wvalid_o,
  output logic                   wlast_o,
  input  logic [N_INIT_PORT-1:0] wready_i,
  output logic                   err_burst_done_o,
  output logic                   wlast_mismatch_o
);

  localparam int unsigned EntryW = 1 + N_INIT_PORT + LEN_WIDTH;

  typedef struct packed {
    logic                   error;
    logic [N_INIT_PORT-1:0] dest;
    logic [LEN_WIDTH-1:0]   len;
  } entry_t;

  entry_t              push_entry, head;
  logic [EntryW-1:0]   head_raw;
  logic                fifo_empty, accept, last_beat, pop;
  logic [1:0]          mode;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                err_done_q, err_done_d, mismatch_q, mismatch_d;

  assign push_entry = '{error: error_i, dest: DEST_i, len: len_i};
  assign head       = head_raw;

  generic_fifo #(
    .DATA_WIDTH(EntryW),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .test_en_i(test_en_i),
    .push_i   (push_DEST_i),
    .data_i   (push_entry),
    .gnt_o    (grant_FIFO_DEST_o),
    .pop_i    (pop),
    .data_o   (head_raw),
    .empty_o  (fifo_empty)
  );

  always_comb begin
    mode = ModeIdle;
    if (!fifo_empty) mode = head.error ? ModeSink : ModeRoute;
  end

  assign last_beat = (beat_cnt_q == head.len);

  always_comb begin
    wready_o = 1'b0;
    wvalid_o = '0;
    wlast_o  = 1'b0;
    unique case (mode)
      ModeRoute: begin
        wvalid_o = {N_INIT_PORT{wvalid_i}} & head.dest;
        wready_o = |(wready_i & head.dest);
        wlast_o  = last_beat;
      end
      ModeSink: wready_o = 1'b1;
      default: ;
    endcase
  end

  assign accept = wvalid_i & wready_o;
  assign pop    = accept & last_beat;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (accept) beat_cnt_d = last_beat ? '0 : beat_cnt_q + LEN_WIDTH'(1);
    err_done_d = pop & (mode == ModeSink);
    mismatch_d = accept & (wlast_i != last_beat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      err_done_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      err_done_q <= err_done_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign err_burst_done_o = err_done_q;
  assign wlast_mismatch_o = mismatch_q;

  a_dest_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    (push_DEST_i && !error_i) |-> $onehot(DEST_i));
  a_wvalid_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(wvalid_o));
  a_push_granted: assert property (@(posedge clk) disable iff (!rst_n)
    push_DEST_i |-> grant_FIFO_DEST_o);

endmodule
